axis_rr_arbiter: RTL and testbench

//   Packet-level round-robin arbiter sharing one 8-bit AXI-Stream sink
//   (skid_buff input -> AXI_slave) between N AXI_master sources.

---
 rtl/axis_rr_arbiter_if.sv | 13 +
 rtl/axis_rr_arbiter.sv | 101 ++++++++++
 tb/tb_axis_rr_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_rr_arbiter_if.sv
// rtl/axis_rr_arbiter_if.sv - byte-stream bundle, LANES parallel lanes sharing one tdata vector
interface axis_rr_arbiter_if #(
  parameter int LANES = 1,
  parameter int DW    = 8
);
  logic [LANES*DW-1:0] tdata;
  logic [LANES-1:0]    tvalid;
  logic [LANES-1:0]    tlast;
  logic [LANES-1:0]    tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_rr_arbiter.sv
// rtl/axis_rr_arbiter.sv - packet-level round-robin arbiter for N sources onto one stream
module axis_rr_arbiter #(
  parameter int  N   = 2,
  parameter int  DW  = 8,
  localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  axis_rr_arbiter_if.slave  s,
  axis_rr_arbiter_if.master m,
  output logic [IDW-1:0]    grant_id,
  output logic              busy,
  output logic [15:0]       pkt_count
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic [IDW-1:0] rr_ptr;
  logic           pick_found;
  logic [IDW-1:0] pick_idx;
  logic           xfer_last;
  int             cand;

  // First requester at or after rr_ptr, wrapping modulo N.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int k = 0; k < N; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= N) begin
        cand = cand - N;
      end
      if (!pick_found && s.tvalid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = IDW'(cand);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    xfer_last = 1'b0;
    s.tready  = '0;
    m.tdata   = '0;
    m.tvalid  = '0;
    m.tlast   = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        m.tdata            = s.tdata[int'(grant_id)*DW +: DW];
        m.tvalid[0]        = s.tvalid[grant_id];
        m.tlast[0]         = s.tlast[grant_id];
        s.tready[grant_id] = m.tready[0];
        xfer_last          = s.tvalid[grant_id] & m.tready[0] & s.tlast[grant_id];
        if (xfer_last) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // grant_id is left alone on release so it reports the last granted source.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr    <= '0;
      grant_id  <= '0;
      busy      <= 1'b0;
      pkt_count <= '0;
    end else begin
      if (state_q == ST_IDLE && pick_found) begin
        grant_id <= pick_idx;
        busy     <= 1'b1;
      end
      if (xfer_last) begin
        busy      <= 1'b0;
        rr_ptr    <= (grant_id == IDW'(N - 1)) ? '0 : grant_id + 1'b1;
        pkt_count <= pkt_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// tb/tb_axis_rr_arbiter.sv - directed and randomized checks of axis_rr_arbiter against a packet-level model
module tb_axis_rr_arbiter;
  localparam int N   = 2;
  localparam int DW  = 8;
  localparam int IDW = 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  axis_rr_arbiter_if #(.LANES(N), .DW(DW)) s_if ();
  axis_rr_arbiter_if #(.LANES(1), .DW(DW)) m_if ();
  logic [IDW-1:0] grant_id;
  logic           busy;
  logic [15:0]    pkt_count;

  axis_rr_arbiter #(.N(N), .DW(DW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .s         (s_if),
    .m         (m_if),
    .grant_id  (grant_id),
    .busy      (busy),
    .pkt_count (pkt_count)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // source drivers: queue of {last,data} beats per source
  logic [8:0] src_q  [N][$];
  logic [8:0] sent_q [N][$];
  logic [8:0] rx_src [N][$];
  logic [N-1:0] cur_valid;
  logic [7:0]   drv_data [N];
  logic [N-1:0] drv_last;
  logic         drv_ready;
  int gap_pct = 100;
  int ready_mode = 0;

  // model: owner=-1 means nobody holds the link
  int owner = -1;
  int next_pri = 0;
  int exp_cnt = 0;
  int exp_gid = 0;

  logic [7:0] rx_q [$];
  int rx_cyc [$];
  int order_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      if (cur_valid[i]) begin
        drv_data[i] = src_q[i][0][7:0];
        drv_last[i] = src_q[i][0][8];
      end else begin
        drv_data[i] = 8'($urandom);
        drv_last[i] = 1'($urandom);
      end
      s_if.tdata[i*DW +: DW] = drv_data[i];
      s_if.tlast[i]          = drv_last[i];
      s_if.tvalid[i]         = cur_valid[i];
    end
    m_if.tready[0] = drv_ready;
  endtask

  task automatic push_seq(input int src, input int first, input int stepv, input int len);
    logic [8:0] b;
    for (int j = 0; j < len; j++) begin
      b = {(j == len - 1), 8'(first + j * stepv)};
      src_q[src].push_back(b);
      sent_q[src].push_back(b);
    end
  endtask

  task automatic clear_obs();
    rx_q.delete();
    rx_cyc.delete();
    order_q.delete();
  endtask

  task automatic step();
    logic [7:0]   e_data;
    logic         e_valid;
    logic         e_last;
    logic [N-1:0] e_ready;
    logic [N-1:0] hs;
    int pick;
    @(negedge clk);
    cyc++;
    e_data = '0; e_valid = 1'b0; e_last = 1'b0; e_ready = '0;
    if (owner >= 0) begin
      e_data         = drv_data[owner];
      e_valid        = cur_valid[owner];
      e_last         = drv_last[owner];
      e_ready[owner] = drv_ready;
    end
    chk("m_data", m_if.tdata, e_data);
    chk("m_valid", m_if.tvalid, e_valid);
    chk("m_last", m_if.tlast, e_last);
    chk("s_ready", s_if.tready, e_ready);
    chk("busy", busy, owner >= 0);
    chk("grant_id", grant_id, exp_gid);
    chk("pkt_count", pkt_count, exp_cnt);
    if (m_if.tvalid[0] && m_if.tready[0]) begin
      rx_q.push_back(m_if.tdata);
      rx_cyc.push_back(cyc);
      rx_src[grant_id].push_back({m_if.tlast[0], m_if.tdata});
      if (m_if.tlast[0]) order_q.push_back(int'(grant_id));
    end
    for (int i = 0; i < N; i++) hs[i] = cur_valid[i] && s_if.tready[i];
    if (owner < 0) begin
      for (int k = 0; k < N; k++) begin
        pick = (next_pri + k) % N;
        if (owner < 0 && cur_valid[pick]) begin
          owner   = pick;
          exp_gid = pick;
        end
      end
    end else if (cur_valid[owner] && drv_ready && drv_last[owner]) begin
      next_pri = (owner + 1) % N;
      exp_cnt  = (exp_cnt + 1) % 65536;
      owner    = -1;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (hs[i]) begin
        void'(src_q[i].pop_front());
        cur_valid[i] = 1'b0;
      end
      if (!cur_valid[i] && src_q[i].size() > 0 && int'($urandom_range(0, 99)) < gap_pct)
        cur_valid[i] = 1'b1;
    end
    case (ready_mode)
      0:       drv_ready = 1'b1;
      1:       drv_ready = ~drv_ready;
      default: drv_ready = ($urandom_range(0, 3) != 0);
    endcase
    apply();
  endtask

  task automatic do_reset(input int ncyc);
    reset_n = 1'b0;
    owner = -1; next_pri = 0; exp_cnt = 0; exp_gid = 0;
    for (int i = 0; i < N; i++) begin
      src_q[i].delete();
      sent_q[i].delete();
      rx_src[i].delete();
    end
    cur_valid = '0;
    drv_ready = 1'b1;
    for (int c = 0; c < ncyc; c++) begin
      apply();
      s_if.tvalid = N'($urandom);
      @(negedge clk);
      chk("rst_m_valid", m_if.tvalid, 0);
      chk("rst_m_last", m_if.tlast, 0);
      chk("rst_m_data", m_if.tdata, 0);
      chk("rst_s_ready", s_if.tready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_grant_id", grant_id, 0);
      chk("rst_pkt_count", pkt_count, 0);
      @(posedge clk);
      #1;
    end
    apply();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    clear_obs();
  endtask

  function automatic bit pending();
    for (int i = 0; i < N; i++) if (src_q[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (pending() && n < budget) begin
      step();
      n++;
    end
    chk({tag, "_timeout"}, n < budget, 1);
    step();
    step();
  endtask

  task automatic chk_seq(input string tag, input int off, input int first, input int stepv, input int len);
    logic [7:0] e;
    for (int j = 0; j < len; j++) begin
      e = 8'(first + j * stepv);
      chk(tag, (off + j < rx_q.size()) ? rx_q[off + j] : 8'hxx, e);
    end
  endtask

  initial begin
    int exp3 [4];
    int exp6 [8];
    int n;
    int plen;
    exp3 = '{0, 1, 0, 0};
    exp6 = '{0, 1, 0, 1, 0, 1, 0, 1};
    cur_valid = '0;
    drv_ready = 1'b1;
    apply();

    // 1: single packet from source 0 at full rate
    do_reset(3);
    push_seq(0, 1, 1, 8);
    drain("t1", 40);
    chk("t1_len", rx_q.size(), 8);
    chk_seq("t1_data", 0, 1, 1, 8);
    chk("t1_span", (rx_q.size() == 8) ? rx_cyc[7] - rx_cyc[0] : -1, 7);
    chk("t1_pkt_count", pkt_count, 1);
    chk("t1_grant_id", grant_id, 0);

    // 2: both sources load in the same cycle
    do_reset(1);
    push_seq(0, 1, 1, 8);
    push_seq(1, 8'h11, 8'h11, 8);
    drain("t2", 60);
    chk("t2_len", rx_q.size(), 16);
    chk_seq("t2_data0", 0, 1, 1, 8);
    chk_seq("t2_data1", 8, 8'h11, 8'h11, 8);
    chk("t2_bubble", (rx_q.size() == 16) ? rx_cyc[8] - rx_cyc[7] : -1, 2);
    chk("t2_orders", order_q.size(), 2);

    // 3: source 0 back-to-back while source 1 waits
    do_reset(1);
    for (int p = 0; p < 3; p++) push_seq(0, 8'hA0 + p * 16, 1, 3);
    push_seq(1, 8'hC0, 1, 3);
    drain("t3", 60);
    chk("t3_orders", order_q.size(), 4);
    for (int j = 0; j < 4; j++) chk("t3_order", (j < order_q.size()) ? order_q[j] : -1, exp3[j]);

    // 4: downstream ready toggled every cycle
    do_reset(1);
    ready_mode = 1;
    push_seq(0, 1, 1, 8);
    drain("t4", 60);
    ready_mode = 0;
    chk("t4_len", rx_q.size(), 8);
    chk_seq("t4_data", 0, 1, 1, 8);
    chk("t4_orders", order_q.size(), 1);

    // 5: reset in the middle of a packet
    do_reset(1);
    push_seq(0, 1, 1, 8);
    n = 0;
    while (rx_q.size() < 3 && n < 50) begin
      step();
      n++;
    end
    chk("t5_wait_timeout", n < 50, 1);
    do_reset(3);
    push_seq(1, 1, 1, 8);
    drain("t5", 40);
    chk("t5_len", rx_q.size(), 8);
    chk_seq("t5_data", 0, 1, 1, 8);
    chk("t5_grant_id", grant_id, 1);
    chk("t5_pkt_count", pkt_count, 1);

    // 6: single-beat packets alternate between sources
    do_reset(1);
    for (int r = 0; r < 4; r++) begin
      push_seq(0, 8'h40 + r, 1, 1);
      push_seq(1, 8'h50 + r, 1, 1);
    end
    drain("t6", 60);
    chk("t6_orders", order_q.size(), 8);
    for (int j = 0; j < 8; j++) chk("t6_order", (j < order_q.size()) ? order_q[j] : -1, exp6[j]);
    chk("t6_pkt_count", pkt_count, 8);

    // 7: random packets, random source gaps, random backpressure
    do_reset(1);
    gap_pct = 60;
    ready_mode = 2;
    for (int i = 0; i < N; i++)
      for (int p = 0; p < 15; p++) begin
        plen = int'($urandom_range(1, 6));
        push_seq(i, int'($urandom_range(0, 255)), int'($urandom_range(1, 7)), plen);
      end
    drain("t7", 3000);
    for (int i = 0; i < N; i++) begin
      chk("t7_src_len", rx_src[i].size(), sent_q[i].size());
      for (int j = 0; j < sent_q[i].size(); j++)
        chk("t7_src_beat", (j < rx_src[i].size()) ? rx_src[i][j] : 9'hxxx, sent_q[i][j]);
    end
    chk("t7_pkt_count", pkt_count, 30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
